// File: rtl/block_xfer_sequencer_pkg.sv
// Shared widths, state encoding and word stride for the LDM/STM block-transfer sequencer.
package block_xfer_sequencer_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int NUM_REGS    = 16;
  localparam int ADDR_WIDTH  = 4;
  localparam int CNT_WIDTH   = $clog2(NUM_REGS + 1);
  localparam int WORD_STRIDE = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_DRAIN,
    ST_WB,
    ST_DONE
  } state_t;

endpackage

// File: rtl/block_xfer_sequencer_reg_list_scan.sv
// Combinational scan of a register mask: lowest set index, any-set flag and popcount.
module block_xfer_sequencer_reg_list_scan
  import block_xfer_sequencer_pkg::*;
(
  input  logic [NUM_REGS-1:0]   mask,
  output logic [ADDR_WIDTH-1:0] low_idx,
  output logic                  found,
  output logic [CNT_WIDTH-1:0]  count
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    low_idx = '0;
    found   = 1'b0;
    count   = '0;
    // Walking from the top down leaves the lowest set index as the final assignment.
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_idx = ADDR_WIDTH'(i);
        found   = 1'b1;
        count   = count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/block_xfer_sequencer.sv
// LDM/STM block-transfer sequencer between register file ports and a word memory handshake.
// Optional SEQ_PC_LOAD_EN routes r15 loads to the pc write port instead of rd.
module block_xfer_sequencer
  import block_xfer_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  up,
  input  logic                  pre,
  input  logic                  writeback,
  input  logic [ADDR_WIDTH-1:0] base_reg,
  input  logic [WORD_SIZE-1:0]  base_val,
  input  logic [NUM_REGS-1:0]   reg_list,
  output logic [ADDR_WIDTH-1:0] read_rn,
  input  logic [WORD_SIZE-1:0]  rn_out,
  output logic                  rd_we,
  output logic [ADDR_WIDTH-1:0] write_rd,
  output logic [WORD_SIZE-1:0]  rd_in,
  output logic                  pc_we,
  output logic [WORD_SIZE-1:0]  pc_in,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic                  mem_ack,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  output logic                  busy,
  output logic                  done
);

  localparam logic [WORD_SIZE-1:0] STRIDE = WORD_SIZE'(WORD_STRIDE);
`ifdef SEQ_PC_LOAD_EN
  localparam logic [ADDR_WIDTH-1:0] PC_IDX = ADDR_WIDTH'(NUM_REGS - 1);
`endif

  state_t                state_q, state_d;
  logic                  is_load_q, writeback_q;
  logic [ADDR_WIDTH-1:0] base_reg_q;
  logic [NUM_REGS-1:0]   list_q, list_orig_q;
  logic [WORD_SIZE-1:0]  addr_q, new_base_q;
  logic                  wr_valid_q;
  logic [ADDR_WIDTH-1:0] wr_idx_q;
  logic [WORD_SIZE-1:0]  wr_data_q;

  logic [NUM_REGS-1:0]   scan_mask, list_next;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic                  any_set;
  logic [CNT_WIDTH-1:0]  count;
  logic [WORD_SIZE-1:0]  span, start_addr, new_base;
  logic                  xfer_ack, wb_en;

  // In IDLE the scanner sizes the incoming command; otherwise it walks the remaining list.
  assign scan_mask = (state_q == ST_IDLE) ? reg_list : list_q;

  block_xfer_sequencer_reg_list_scan u_reg_list_scan (
    .mask    (scan_mask),
    .low_idx (cur_idx),
    .found   (any_set),
    .count   (count)
  );

  assign span      = WORD_SIZE'(count) * STRIDE;
  assign new_base  = up ? (base_val + span) : (base_val - span);
  assign xfer_ack  = (state_q == ST_XFER) && mem_ack;
  assign list_next = list_q & (list_q - NUM_REGS'(1));
  // A loaded base register wins over the writeback value.
  assign wb_en     = writeback_q && !(is_load_q && list_orig_q[base_reg_q]);

  always_comb begin
    case ({up, pre})
      2'b10:   start_addr = base_val;
      2'b11:   start_addr = base_val + STRIDE;
      2'b00:   start_addr = base_val - span + STRIDE;
      default: start_addr = base_val - span;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = any_set ? ST_XFER : ST_DONE;
      ST_XFER:  if (mem_ack && (list_next == '0)) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_WB;
      ST_WB:    state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_load_q   <= 1'b0;
      writeback_q <= 1'b0;
      base_reg_q  <= '0;
      list_q      <= '0;
      list_orig_q <= '0;
      addr_q      <= '0;
      new_base_q  <= '0;
      wr_valid_q  <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        is_load_q   <= is_load;
        writeback_q <= writeback;
        base_reg_q  <= base_reg;
        list_q      <= reg_list;
        list_orig_q <= reg_list;
        addr_q      <= start_addr;
        new_base_q  <= new_base;
      end
      if (xfer_ack) begin
        list_q    <= list_next;
        addr_q    <= addr_q + STRIDE;
        wr_idx_q  <= cur_idx;
        wr_data_q <= mem_rdata;
      end
      // Load data is written back the cycle after its ack, so the last one lands in DRAIN.
      wr_valid_q <= xfer_ack && is_load_q;
    end
  end

  always_comb begin
    read_rn   = '0;
    rd_we     = 1'b0;
    write_rd  = '0;
    rd_in     = '0;
    pc_we     = 1'b0;
    pc_in     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);

    if (state_q == ST_XFER) begin
      mem_req  = 1'b1;
      mem_we   = !is_load_q;
      mem_addr = addr_q;
      if (!is_load_q) begin
        read_rn   = cur_idx;
        mem_wdata = rn_out;
      end
    end

    if (wr_valid_q) begin
`ifdef SEQ_PC_LOAD_EN
      if (wr_idx_q == PC_IDX) begin
        pc_we = 1'b1;
        pc_in = wr_data_q;
      end else begin
        rd_we    = 1'b1;
        write_rd = wr_idx_q;
        rd_in    = wr_data_q;
      end
`else
      rd_we    = 1'b1;
      write_rd = wr_idx_q;
      rd_in    = wr_data_q;
`endif
    end

    if ((state_q == ST_WB) && wb_en) begin
      rd_we    = 1'b1;
      write_rd = base_reg_q;
      rd_in    = new_base_q;
    end
  end

endmodule

// File: tb/tb_block_xfer_sequencer.sv
// Scoreboard bench for block_xfer_sequencer: directed LDM/STM commands, queued expectations, negedge monitor.
module tb_block_xfer_sequencer;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic        pc;
    logic [3:0]  idx;
    logic [31:0] data;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        reset, start, is_load, up, pre, writeback;
  logic [3:0]  base_reg;
  logic [31:0] base_val;
  logic [15:0] reg_list;
  logic [3:0]  read_rn;
  logic [31:0] rn_out;
  logic        rd_we;
  logic [3:0]  write_rd;
  logic [31:0] rd_in;
  logic        pc_we;
  logic [31:0] pc_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata;
  logic        busy, done;

  mem_exp_t mem_q[$];
  wr_exp_t  wr_q[$];
  int       done_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_seen = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  block_xfer_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_load   (is_load),
    .up        (up),
    .pre       (pre),
    .writeback (writeback),
    .base_reg  (base_reg),
    .base_val  (base_val),
    .reg_list  (reg_list),
    .read_rn   (read_rn),
    .rn_out    (rn_out),
    .rd_we     (rd_we),
    .write_rd  (write_rd),
    .rd_in     (rd_in),
    .pc_we     (pc_we),
    .pc_in     (pc_in),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done)
  );

  // Register file read model and memory data model.
  assign rn_out    = 32'hA5A5_0000 | {28'd0, read_rn};
  assign mem_rdata = mem_ack ? (32'hD000_0000 | mem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory responder: ack after ack_delay waiting cycles of each request.
  always @(posedge clk) begin
    #1;
    if (reset || !mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      mem_ack  = 1'b1;
      wait_cnt = 0;
    end else begin
      mem_ack  = 1'b0;
      wait_cnt++;
    end
  end

  // Monitor: compares every observed transfer, register write and done pulse with the queues.
  always @(negedge clk) begin
    mem_exp_t m;
    wr_exp_t  w;
    if (!reset) begin
      if (mem_req) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
        end else if (mem_ack) begin
          m = mem_q.pop_front();
          check("mem_addr", mem_addr, m.addr);
          check("mem_we", {31'd0, mem_we}, {31'd0, m.we});
          if (m.we) check("mem_wdata", mem_wdata, m.wdata);
        end else begin
          m = mem_q[0];
          check("mem_addr_hold", mem_addr, m.addr);
          check("mem_we_hold", {31'd0, mem_we}, {31'd0, m.we});
          if (m.we) check("mem_wdata_hold", mem_wdata, m.wdata);
        end
      end
      if (rd_we || pc_we) begin
        check("write_port_excl", {31'd0, rd_we & pc_we}, 32'd0);
        if (wr_q.size() == 0) begin
          check("unexpected_write", {30'd0, rd_we, pc_we}, 32'd0);
        end else begin
          w = wr_q.pop_front();
          check("write_is_pc", {31'd0, pc_we}, {31'd0, w.pc});
          if (w.pc) begin
            check("pc_in", pc_in, w.data);
          end else begin
            check("write_rd", {28'd0, write_rd}, {28'd0, w.idx});
            check("rd_in", rd_in, w.data);
          end
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected_done", {31'd0, done}, 32'd0);
        else check("done_cycle", cyc, done_q.pop_front());
        done_seen++;
      end
    end
  end

  task automatic issue(input logic ld, input logic up_i, input logic pre_i, input logic wb_i,
                       input logic [3:0] br, input logic [31:0] bv, input logic [15:0] rl,
                       input int delay, output int k);
    @(posedge clk);
    #2;
    ack_delay = delay;
    is_load   = ld;
    up        = up_i;
    pre       = pre_i;
    writeback = wb_i;
    base_reg  = br;
    base_val  = bv;
    reg_list  = rl;
    start     = 1'b1;
    k         = cyc;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_seen < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("done_within_budget", done_seen, target);
  endtask

  function automatic mem_exp_t mx(input logic [31:0] a, input logic we, input logic [31:0] d);
    mem_exp_t e;
    e.addr = a; e.we = we; e.wdata = d;
    return e;
  endfunction

  function automatic wr_exp_t wx(input logic pc, input logic [3:0] idx, input logic [31:0] d);
    wr_exp_t e;
    e.pc = pc; e.idx = idx; e.data = d;
    return e;
  endfunction

  initial begin
    int k;
    int target = 0;
    reset = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0; writeback = 1'b0;
    base_reg = '0; base_val = '0; reg_list = '0;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_rd_we", {31'd0, rd_we}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // LDMIA r0!, {r1,r3}: zero-wait memory
    mem_q.push_back(mx(32'h100, 1'b0, 32'h0));
    mem_q.push_back(mx(32'h104, 1'b0, 32'h0));
    wr_q.push_back(wx(1'b0, 4'd1, 32'hD000_0100));
    wr_q.push_back(wx(1'b0, 4'd3, 32'hD000_0104));
    wr_q.push_back(wx(1'b0, 4'd0, 32'h0000_0108));
    issue(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 32'h100, 16'h000A, 0, k);
    done_q.push_back(k + 5);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(++target, 40);

    // STMDB r13!, {r0,r1,r15}: two wait cycles per transfer
    mem_q.push_back(mx(32'h1F4, 1'b1, 32'hA5A5_0000));
    mem_q.push_back(mx(32'h1F8, 1'b1, 32'hA5A5_0001));
    mem_q.push_back(mx(32'h1FC, 1'b1, 32'hA5A5_000F));
    wr_q.push_back(wx(1'b0, 4'd13, 32'h0000_01F4));
    issue(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h200, 16'h8003, 2, k);
    done_q.push_back(k + 12);
    wait_done(++target, 60);

    // LDMIB r2!, {r2}: loaded value wins, no writeback
    mem_q.push_back(mx(32'h304, 1'b0, 32'h0));
    wr_q.push_back(wx(1'b0, 4'd2, 32'hD000_0304));
    issue(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 32'h300, 16'h0004, 0, k);
    done_q.push_back(k + 4);
    wait_done(++target, 40);

    // Empty list: straight to DONE
    issue(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'h400, 16'h0000, 0, k);
    done_q.push_back(k + 1);
    wait_done(++target, 20);

    // Reset while a store is waiting for ack
    mem_q.push_back(mx(32'h500, 1'b1, 32'hA5A5_0004));
    issue(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h500, 16'h00F0, 4, k);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_mem_wdata", mem_wdata, 32'd0);
    check("midrst_read_rn", {28'd0, read_rn}, 32'd0);
    check("midrst_rd_we", {31'd0, rd_we}, 32'd0);
    mem_q.delete();
    wr_q.delete();
    done_q.delete();
    @(posedge clk);
    #2 reset = 1'b0;

    // LDMDA {r0} with one wait cycle; a second start while busy must be ignored
    mem_q.push_back(mx(32'h600, 1'b0, 32'h0));
    wr_q.push_back(wx(1'b0, 4'd0, 32'hD000_0600));
    issue(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h600, 16'h0001, 1, k);
    done_q.push_back(k + 5);
    @(posedge clk);
    #2;
    is_load = 1'b0; reg_list = 16'h00FF; base_val = 32'h900; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(++target, 40);

    // Next command after the ignored start runs normally: STMIA {r5,r6}
    mem_q.push_back(mx(32'h700, 1'b1, 32'hA5A5_0005));
    mem_q.push_back(mx(32'h704, 1'b1, 32'hA5A5_0006));
    issue(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h700, 16'h0060, 0, k);
    done_q.push_back(k + 5);
    wait_done(++target, 40);

    // LDMIA {r15}
    mem_q.push_back(mx(32'h800, 1'b0, 32'h0));
`ifdef SEQ_PC_LOAD_EN
    wr_q.push_back(wx(1'b1, 4'd15, 32'hD000_0800));
`else
    wr_q.push_back(wx(1'b0, 4'd15, 32'hD000_0800));
`endif
    issue(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h800, 16'h8000, 0, k);
    done_q.push_back(k + 4);
    wait_done(++target, 40);

    repeat (3) @(posedge clk);
    check("mem_queue_drained", mem_q.size(), 32'd0);
    check("write_queue_drained", wr_q.size(), 32'd0);
    check("done_queue_drained", done_q.size(), 32'd0);
    check("idle_at_end", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/block_xfer_sequencer.md
Name: block_xfer_sequencer

Overview:
- Sequences ARM LDM/STM block transfers through the register file's single read port (rn) and single write port (rd) and a word-wide memory handshake.
- Walks the 16-bit register list from lowest to highest index and generates word addresses.
- For loads, writes the fetched data into the register file; for stores, reads register values out to memory.
- Performs optional base-register writeback. Sits between decode/execute control and register_file/memory interface.

Parameters:
- WORD_SIZE, 32, data/address width
- NUM_REGS, 16, register count and reg_list width
- ADDR_WIDTH, 4, register index width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- is_load  in  1  1=LDM, 0=STM
- up  in  1  1=increment, 0=decrement
- pre  in  1  1=before (IB/DB), 0=after (IA/DA)
- writeback  in  1  update base register at end
- base_reg  in  ADDR_WIDTH  base register index
- base_val  in  WORD_SIZE  base register value
- reg_list  in  NUM_REGS  register mask
- read_rn  out  ADDR_WIDTH  register file read index
- rn_out  in  WORD_SIZE  register file read data (combinational)
- rd_we  out  1  register file write enable
- write_rd  out  ADDR_WIDTH  register file write index
- rd_in  out  WORD_SIZE  register file write data
- pc_we  out  1  pc write enable
- pc_in  out  WORD_SIZE  pc write data
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  WORD_SIZE  word address
- mem_wdata  out  WORD_SIZE  store data
- mem_ack  in  1  memory completion
- mem_rdata  in  WORD_SIZE  load data
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Clock is clk. Reset is asynchronous and active-high (reset).
- Reset or reset mid-operation: state goes to IDLE and the latched command is discarded. All outputs are 0: rd_we, pc_we, mem_req, mem_we, done, busy, and all buses.
- Command latch: start in IDLE latches all command inputs and computes n = popcount(reg_list).
- Start address:
  - IA: base_val
  - IB: base_val + 4
  - DA: base_val - 4n + 4
  - DB: base_val - 4n
  - All arithmetic is modulo 2^WORD_SIZE.
- New base value: base_val + 4n when up=1; base_val - 4n when up=0.
- States: IDLE -> XFER -> DRAIN -> WB -> DONE -> IDLE. start while busy is ignored.
- IDLE -> XFER: on start, when n > 0.
- IDLE -> DONE: on start, when n = 0. No memory access, no writeback.
- XFER:
  - Current register = lowest set bit of the remaining list.
  - mem_req = 1; mem_addr and mem_we (= !is_load) are held stable until mem_ack.
  - Store: read_rn = current register; mem_wdata = rn_out, passed through combinationally.
  - On the edge with mem_ack = 1: clear that list bit and advance the address by 4.
  - Load, on that same edge: register the write. In the following cycle, rd_we = 1 for exactly one cycle with write_rd = current register and rd_in = mem_rdata.
  - When the remaining list becomes empty, go to DRAIN. mem_req drops in DRAIN.
  - mem_req is never asserted in back-to-back transfers before ack; one outstanding request at a time.
- DRAIN: one cycle. It carries the final load write pulse (no write when is_load = 0). Go to WB.
- WB: one cycle. If writeback = 1 and not (is_load = 1 and reg_list[base_reg] = 1), then rd_we = 1, write_rd = base_reg, rd_in = new base. Otherwise no write, because the loaded value wins. Go to DONE.
- DONE: done = 1 for one cycle. Go to IDLE.
- Write-port rule: at most one of rd_we / pc_we is high per cycle, by construction.
- Minimum latency with zero-wait memory (ack in first XFER cycle): start to done = n + 3 cycles.

Optional Feature:
- Macro: SEQ_PC_LOAD_EN.
- Defined: a load targeting r15 asserts pc_we/pc_in (= mem_rdata) instead of rd_we; rd_we stays 0 that cycle.
- Undefined: r15 loads use rd_we with write_rd = 15. pc_we and pc_in are tied to 0.

Decomposition:
- Shared package: WORD_SIZE, NUM_REGS, ADDR_WIDTH; state encoding (IDLE, XFER, DRAIN, WB, DONE); word stride constant 4.
- Sub-module reg_list_scan (combinational): lowest-set-bit index, valid flag and popcount of a NUM_REGS-wide mask.

Test Plan:
- LDMIA, base_val = 0x100, list = 0x000A, writeback = 1, base_reg = 0, zero-wait ack -> reads at 0x100 and 0x104; rd writes r1 then r3; WB writes r0 = 0x108; done at start + 5.
- STMDB, base_val = 0x200, list = 0x8003, mem_ack delayed 2 cycles each -> addresses 0x1F4, 0x1F8, 0x1FC; read_rn sequence 0, 1, 15; mem_addr and mem_wdata stable while waiting.
- LDMIB with base_reg = 2 in list = 0x0004, writeback = 1 -> single read at base + 4; r2 = loaded data; no WB write.
- list = 0x0000, start -> no mem_req; done one cycle after start; no rd_we.
- Reset asserted mid-XFER, and start pulsed while busy -> outputs clear immediately; the busy-time start is ignored and the next start runs normally.
- SEQ_PC_LOAD_EN defined, LDMIA list = 0x8000 -> pc_we = 1, pc_in = mem_rdata, rd_we = 0. Undefined -> rd_we = 1, write_rd = 15.
